gate_test_sequencer: RTL

Controller that exhaustively exercises one small combinational gate (NAND, AND, OR, XOR and similar curated gates).
- Drives every input vector in ascending order and holds each for a programmable number of cycles.
- Samples the gate output and compares it against a parameterised truth table.
- Reports mismatch count and first failing vector.
- Sits beside each curated gate as the self-checking stimulus engine that replaces hand-written per-gate initial blocks.

---
 rtl/gate_test_pkg.sv | 23 ++
 rtl/gate_test_sequencer_if.sv | 27 ++
 rtl/hold_timer.sv | 28 ++
 rtl/gate_test_sequencer.sv | 109 ++++++++++
 4 files changed

// File: rtl/gate_test_pkg.sv
// Shared types and constants for the gate test sequencer: FSM encoding,
// truth tables of the curated two-input gates and the dwell-counter sizing helper.
package gate_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Bit i is the expected gate output for input vector i (a = MSB, b = LSB).
  localparam logic [3:0] TT_NAND2 = 4'b0111;
  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_NOR2  = 4'b0001;
  localparam logic [3:0] TT_XOR2  = 4'b0110;
  localparam logic [3:0] TT_XNOR2 = 4'b1001;

  function automatic int unsigned hold_cnt_w(input int unsigned hold_cycles);
    return (hold_cycles <= 1) ? 1 : $clog2(hold_cycles);
  endfunction

endpackage

// File: rtl/gate_test_sequencer_if.sv
// Stimulus/result bundle between the gate test sequencer (master) and the
// gate under test plus whoever collects the verdict (slave).
interface gate_test_sequencer_if #(
  parameter int N_IN = 2
);
  logic            start;
  logic            abort;
  logic [N_IN-1:0] dut_in;
  logic            dut_out;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic [N_IN-1:0] first_fail_vec;
  logic            first_fail_valid;

  modport master (
    input  start, abort, dut_out,
    output dut_in, busy, done, pass, err_count, first_fail_vec, first_fail_valid
  );

  modport slave (
    output start, abort, dut_out,
    input  dut_in, busy, done, pass, err_count, first_fail_vec, first_fail_valid
  );

endinterface

// File: rtl/hold_timer.sv
// Per-vector dwell counter: counts 0..HOLD_CYCLES-1 while enabled, wraps to 0,
// and flags the terminal count so the caller knows when to sample.
module hold_timer #(
  parameter int unsigned HOLD_CYCLES = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign tc = en && (cnt == TERM);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == TERM) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/gate_test_sequencer.sv
// Exhaustive stimulus engine for one small combinational gate: walks every input
// vector in ascending order, samples the gate after a dwell and scores it against TRUTH_TABLE.
module gate_test_sequencer
  import gate_test_pkg::*;
#(
  parameter int                     N_IN        = 2,
  parameter int unsigned            HOLD_CYCLES = 10,
  parameter logic [2**N_IN-1:0]     TRUTH_TABLE = TT_NAND2
) (
  input  logic                 clk,
  input  logic                 rst,
  gate_test_sequencer_if.master bus
);

  localparam logic [1:0]      S_IDLE   = ST_IDLE;
  localparam logic [1:0]      S_APPLY  = ST_APPLY;
  localparam logic [1:0]      S_DONE   = ST_DONE;
  localparam int unsigned     CNT_W    = hold_cnt_w(HOLD_CYCLES);
  localparam logic [N_IN-1:0] LAST_VEC = '1;

  logic [1:0]      state;
  logic [N_IN-1:0] vec;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic [N_IN-1:0] first_fail_vec;
  logic            first_fail_valid;
  logic            tc;
  logic            mismatch;
  logic [N_IN:0]   err_nxt;

  hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .CNT_W       (CNT_W)
  ) u_hold_timer (
    .clk (clk),
    .rst (rst),
    .clr (state != S_APPLY),
    .en  (state == S_APPLY),
    .tc  (tc)
  );

  // Case inequality so an X/Z from the gate scores as a failure in simulation.
  assign mismatch = (bus.dut_out !== TRUTH_TABLE[vec]);
  assign err_nxt  = mismatch ? err_count + (N_IN+1)'(1) : err_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      vec              <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else if (bus.abort) begin
      // Abort drops the run but keeps the partial score for inspection.
      state <= S_IDLE;
      vec   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      case (state)
        S_APPLY: begin
          if (tc) begin
            err_count <= err_nxt;
            if (mismatch && !first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_vec   <= vec;
            end
            if (vec == LAST_VEC) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_nxt == '0);
            end else begin
              vec <= vec + N_IN'(1);
            end
          end
        end
        default: begin
          // IDLE and DONE both launch a fresh run with cleared results.
          if (bus.start) begin
            state            <= S_APPLY;
            vec              <= '0;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.dut_in           = vec;
  assign bus.busy             = busy;
  assign bus.done             = done;
  assign bus.pass             = pass;
  assign bus.err_count        = err_count;
  assign bus.first_fail_vec   = first_fail_vec;
  assign bus.first_fail_valid = first_fail_valid;

endmodule
